// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with per-grant timeout abort.
// One transaction per grant; slave ack/data are routed back to the owner only.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant,
  output logic          timeout_err,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

  state_t     r_state, w_next;
  logic       r_last, w_next_last;
  logic [7:0] r_cnt, w_next_cnt;
  logic       w_sel1, w_stb, w_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end

  assign o_dbg_state = r_state;

  // Handshake: a master holds stb with stable we/addr/dat until its ack;
  // ack is a single-cycle pulse, either the slave's ack or a forced timeout ack.
  always_comb begin
    w_next      = r_state;
    w_next_last = r_last;
    w_next_cnt  = r_cnt;
    w_sel1      = (r_state == GNT1);
    w_stb       = 1'b0;
    w_ack       = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_addr_o    = '0;
    s_dat_o     = '0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m0_dat_o    = '0;
    m1_dat_o    = '0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_cnt = 8'd0;
        if (m0_stb_i && m1_stb_i) w_next = r_last ? GNT0 : GNT1;
        else if (m0_stb_i)        w_next = GNT0;
        else if (m1_stb_i)        w_next = GNT1;
      end
      GNT0, GNT1: begin
        w_stb    = w_sel1 ? m1_stb_i  : m0_stb_i;
        s_we_o   = w_sel1 ? m1_we_i   : m0_we_i;
        s_addr_o = w_sel1 ? m1_addr_i : m0_addr_i;
        s_dat_o  = w_sel1 ? m1_dat_i  : m0_dat_i;
        s_stb_o  = w_stb;
        grant    = w_sel1 ? 2'b10 : 2'b01;
        w_ack    = s_ack_i;
        // Slave ack beats withdrawal, which beats the timeout abort.
        if (s_ack_i || !w_stb) begin
          w_next = IDLE;
        end else if (r_cnt == TERM) begin
          w_ack       = 1'b1;
          timeout_err = 1'b1;
          s_stb_o     = 1'b0;
          w_next      = IDLE;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
        if (w_next == IDLE) begin
          w_next_last = w_sel1;
          w_next_cnt  = 8'd0;
        end
        if (w_sel1) begin
          m1_ack_o = w_ack;
          m1_dat_o = s_dat_i;
        end else begin
          m0_ack_o = w_ack;
          m0_dat_o = s_dat_i;
        end
      end
      default: begin
        w_next     = IDLE;
        w_next_cnt = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4): grant order, routing,
// timeout abort, withdrawal, reset mid-transaction and spurious ack.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_ack_o, m1_ack_o, s_stb_o, s_we_o, s_ack_i, timeout_err;
  logic [1:0]    grant, o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant(grant), .timeout_err(timeout_err), .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_dat_i = '0;
    m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [1:0] g_tab [10] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
  logic       a_tab [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  logic       k0_tab[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  logic       k1_tab[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    do_reset();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_stb", s_stb_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    check("rst_terr", timeout_err, 0);
    check("rst_state", o_dbg_state, 2'd0);

    // spurious ack in IDLE
    s_ack_i = 1; #1;
    check("spur_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    check("spur_dat0", m0_dat_o, 32'h0);
    s_ack_i = 0;

    // m0 read, slave acks on third grant cycle
    m0_stb_i = 1; m0_addr_i = 32'h40; #1;
    check("rd_lat_grant", grant, 2'b00);
    step(); #1;
    check("rd_g1_grant", grant, 2'b01);
    check("rd_g1_stb", s_stb_o, 1);
    check("rd_g1_addr", s_addr_o, 32'h40);
    check("rd_g1_ack", m0_ack_o, 0);
    step(); #1;
    check("rd_g2_ack", m0_ack_o, 0);
    step(); s_ack_i = 1; s_dat_i = 32'hDEADBEEF; #1;
    check("rd_ack0", m0_ack_o, 1);
    check("rd_dat0", m0_dat_o, 32'hDEADBEEF);
    check("rd_ack1", m1_ack_o, 0);
    check("rd_dat1", m1_dat_o, 32'h0);
    check("rd_terr", timeout_err, 0);
    step(); idle_inputs(); #1;
    check("rd_idle", grant, 2'b00);
    check("rd_idle_ack", m0_ack_o, 0);

    // round-robin from reset, both masters always requesting
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(g_tab[i]);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      m0_stb_i = (i < 9); m1_stb_i = (i < 9);
      s_ack_i = a_tab[i]; s_dat_i = 32'hA5A5_0000 + i;
      #1;
      check($sformatf("rr_grant%0d", i), grant, exp_q.pop_front());
      check($sformatf("rr_ack0_%0d", i), m0_ack_o, k0_tab[i]);
      check($sformatf("rr_ack1_%0d", i), m1_ack_o, k1_tab[i]);
    end
    s_ack_i = 0;

    // m1 write while m0 idle
    step(); idle_inputs();
    m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0100; m1_dat_i = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) s_ack_i = 1;
      #1;
      check($sformatf("wr_grant%0d", i), grant, 2'b10);
      check($sformatf("wr_we%0d", i), s_we_o, 1);
      check($sformatf("wr_addr%0d", i), s_addr_o, 32'h100);
      check($sformatf("wr_dat%0d", i), s_dat_o, 32'h12345678);
      check($sformatf("wr_ack1_%0d", i), m1_ack_o, (i == 2));
      check($sformatf("wr_ack0_%0d", i), m0_ack_o, 0);
    end
    step(); idle_inputs(); #1;
    check("wr_idle", grant, 2'b00);

    // timeout abort, then ack exactly on the terminal cycle
    for (int v = 0; v < 2; v++) begin
      m0_stb_i = 1;
      for (int c = 1; c <= 4; c++) begin
        step();
        if (c == 4 && v == 1) s_ack_i = 1;
        #1;
        check($sformatf("to%0d_grant%0d", v, c), grant, 2'b01);
        check($sformatf("to%0d_ack%0d", v, c), m0_ack_o, (c == 4));
        check($sformatf("to%0d_terr%0d", v, c), timeout_err, (c == 4 && v == 0));
        check($sformatf("to%0d_stb%0d", v, c), s_stb_o, (c < 4 || v == 1));
      end
      step(); idle_inputs(); #1;
      check($sformatf("to%0d_idle", v), grant, 2'b00);
      check($sformatf("to%0d_idle_terr", v), timeout_err, 0);
    end

    // reset during GNT1, then tie resolves to m0
    m1_stb_i = 1;
    step(); #1;
    check("rs_grant1", grant, 2'b10);
    reset = 1; #1;
    check("rs_ack1", m1_ack_o, 0);
    step(); #1;
    check("rs_grant0", grant, 2'b00);
    check("rs_stb", s_stb_o, 0);
    check("rs_ack1b", m1_ack_o, 0);
    reset = 0; m0_stb_i = 1; #1;
    check("rs_rel_grant", grant, 2'b00);
    step(); s_ack_i = 1; #1;
    check("rs_tie_grant", grant, 2'b01);
    check("rs_tie_ack0", m0_ack_o, 1);
    check("rs_tie_ack1", m1_ack_o, 0);
    step(); idle_inputs(); #1;

    // m0 withdraws after one granted cycle, pending m1 then granted
    m0_stb_i = 1;
    step(); m1_stb_i = 1; #1;
    check("wd_grant0", grant, 2'b01);
    step(); m0_stb_i = 0; #1;
    check("wd_drop_ack", m0_ack_o, 0);
    check("wd_drop_stb", s_stb_o, 0);
    check("wd_drop_terr", timeout_err, 0);
    step(); #1;
    check("wd_idle", grant, 2'b00);
    check("wd_idle_ack", {m0_ack_o, m1_ack_o}, 2'b00);
    step(); #1;
    check("wd_grant1", grant, 2'b10);
    check("wd_stb1", s_stb_o, 1);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared memory/IO bus.
- Master 0 is the multi-cycle CPU (stb/we/addr/data, ack returned as MIO_ready). Master 1 is a secondary bus master, e.g. a DMA or video fetch engine.
- Grants the bus round-robin, one transaction per grant. Routes slave ack/data back to the granted master only.
- Aborts transactions the slave never acknowledges, using a timeout with error flag.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, cycles in a grant state without s_ack_i before forced abort (1..255, 8-bit counter)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- m0_stb_i  in  1  CPU request strobe, held until ack
- m0_we_i  in  1  CPU write enable
- m0_addr_i  in  AW  CPU address
- m0_dat_i  in  DW  CPU write data
- m0_dat_o  out  DW  read data to CPU
- m0_ack_o  out  1  transaction done to CPU (MIO_ready)
- m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_dat_o, m1_ack_o  as m0_*, for master 1
- s_stb_o  out  1  strobe to slave/bus
- s_we_o  out  1  write enable to slave
- s_addr_o  out  AW  address to slave
- s_dat_o  out  DW  write data to slave
- s_dat_i  in  DW  read data from slave
- s_ack_i  in  1  slave acknowledge
- grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
- timeout_err  out  1  one-cycle pulse, concurrent with the forced ack on abort

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - All state registers update on the rising edge.
- Reset values:
  - state = IDLE, grant = 00, s_stb_o = 0, both acks = 0, timeout_err = 0.
  - Timeout counter = 0.
  - last = 1, so m0 wins the first tie.
- States: IDLE, GNT0, GNT1.
- IDLE transitions:
  - Only m0_stb_i set -> GNT0. Only m1_stb_i set -> GNT1.
  - Both set -> the master not equal to last. None set -> stay in IDLE.
- Grant latency: a request sampled in IDLE at edge N gives grant and s_stb_o high from cycle N+1. Minimum transaction is two cycles.
- Bus outputs in GNTx:
  - s_stb_o = mx_stb_i. s_we_o, s_addr_o and s_dat_o are muxed combinationally from master x.
  - In IDLE all s_* outputs are 0.
- Ack and read data routing:
  - mx_ack_o = s_ack_i, combinational, only while in GNTx. The other master's ack is always 0.
  - mx_dat_o = s_dat_i while in GNTx, else 0.
- Completion: s_ack_i in GNTx -> next state IDLE, last = x, counter cleared. Exactly one transaction per grant.
- Bubble: after an ack there is one mandatory idle cycle before the next grant, giving ack-to-next-s_stb_o = 2 cycles.
- Master withdrawal: mx_stb_i drops in GNTx without ack -> IDLE next cycle, last = x, no ack and no error.
- Timeout:
  - The counter increments each cycle in GNTx without s_ack_i.
  - When counter == TIMEOUT-1 and s_ack_i = 0, for that cycle: mx_ack_o = 1, timeout_err = 1, s_stb_o forced to 0. Next state IDLE, last = x.
  - If s_ack_i arrives in the terminal cycle, normal completion applies and timeout_err stays 0.
- Spurious ack: s_ack_i in IDLE is ignored; no master ack is generated.
- Reset mid-transaction: next cycle is IDLE with all strobes and acks low. The in-flight transaction is dropped without ack.
- Mutual exclusion: grant is never 11. At most one mx_ack_o is high per cycle.

Test Plan:
- m0 read alone, slave acks 2 cycles after s_stb_o with s_dat_i = 0xDEADBEEF -> grant = 01; m0_ack_o one cycle with m0_dat_o = 0xDEADBEEF; m1_ack_o = 0; IDLE afterward.
- Both strobes high from reset, slave acks each strobe after 1 cycle -> grant sequence 01, 00, 10, 00, 01 (round-robin alternation); each master receives exactly one ack per grant.
- m1 write with addr 0x0000_0100 and data 0x12345678 while m0 idle -> s_we_o = 1, s_addr_o = 0x100, s_dat_o = 0x12345678 throughout GNT1.
- TIMEOUT = 4, m0 request, slave never acks -> on the 4th grant cycle m0_ack_o = 1, timeout_err = 1, s_stb_o = 0; next cycle grant = 00. Variant with ack exactly on the 4th cycle -> timeout_err = 0.
- Reset asserted during GNT1 before ack -> next cycle grant = 00, s_stb_o = 0, m1_ack_o never pulses. After reset release with both strobes high -> m0 granted first.
- Master 0 drops m0_stb_i after 1 granted cycle -> no ack, IDLE next cycle; a pending m1 request is granted the following cycle.
